pp_trace_buffer: RTL

- Synthesizable on-chip trace capture for the pipelined core; replaces per-cycle bench-only PC/instruction/memory/register logging.
- Records {PC, instruction, NUM_CH watch words} on every valid commit into a circular buffer of DEPTH entries.
- Supports PC-match trigger with programmable post-trigger count, then freezes.
- Exposes a registered random-access readout port for bench or debug logic.

---
 rtl/pp_trace_buffer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/pp_trace_buffer.sv
// Circular on-chip trace buffer: captures {PC, instr, watch words} per commit, PC trigger with post count.
// Optional per-entry cycle timestamps are built when PP_TRACE_TIMESTAMP_EN is defined.
module pp_trace_buffer #(
   parameter int XLEN   = 32,
   parameter int DEPTH  = 16,
   parameter int NUM_CH = 2,
   parameter int TS_W   = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int FW    = $clog2(NUM_CH + 3)
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   arm,
   input  logic                   abort,
   input  logic [XLEN-1:0]        trig_pc,
   input  logic [AW-1:0]          post_count,
   input  logic                   trace_valid,
   input  logic [XLEN-1:0]        trace_pc,
   input  logic [XLEN-1:0]        trace_instr,
   input  logic [NUM_CH*XLEN-1:0] watch_data,
   output logic [1:0]             state,
   output logic                   triggered,
   output logic [AW-1:0]          wr_ptr,
   output logic [AW:0]            entries,
   input  logic                   rd_en,
   input  logic [AW-1:0]          rd_idx,
   input  logic [FW-1:0]          rd_field,
   output logic [XLEN-1:0]        rd_data,
   output logic                   rd_valid
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   state_t          state_q, state_d;
   logic            triggered_q, triggered_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]     entries_q, entries_d;
   logic [AW-1:0]   remain_q, remain_d;
   logic            wr_en;

   logic [XLEN-1:0]        pc_mem    [DEPTH];
   logic [XLEN-1:0]        instr_mem [DEPTH];
   logic [NUM_CH*XLEN-1:0] watch_mem [DEPTH];

   logic [AW-1:0]   rd_addr;
   logic            rd_hit;
   logic [XLEN-1:0] rd_word;
   logic [TS_W-1:0] ts_rd;
   logic [XLEN-1:0] rd_data_q;
   logic            rd_valid_q;

   always_comb begin
      state_d     = state_q;
      triggered_d = triggered_q;
      wr_ptr_d    = wr_ptr_q;
      entries_d   = entries_q;
      remain_d    = remain_q;
      wr_en       = 1'b0;
      if (abort) begin
         // Pointers and count are held so an aborted capture stays readable.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (arm) begin
                  state_d     = S_ARMED;
                  wr_ptr_d    = '0;
                  entries_d   = '0;
                  triggered_d = 1'b0;
               end
            end
            S_ARMED: begin
               if (trace_valid) begin
                  wr_en     = 1'b1;
                  wr_ptr_d  = wr_ptr_q + PTR_ONE;
                  entries_d = (entries_q == CNT_FULL) ? entries_q : entries_q + CNT_ONE;
                  if (trace_pc == trig_pc) begin
                     triggered_d = 1'b1;
                     remain_d    = post_count;
                     state_d     = (post_count == '0) ? S_DONE : S_POST;
                  end
               end
            end
            S_POST: begin
               if (trace_valid) begin
                  wr_en     = 1'b1;
                  wr_ptr_d  = wr_ptr_q + PTR_ONE;
                  entries_d = (entries_q == CNT_FULL) ? entries_q : entries_q + CNT_ONE;
                  remain_d  = remain_q - PTR_ONE;
                  if (remain_q == PTR_ONE) begin
                     state_d = S_DONE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= S_IDLE;
         triggered_q <= 1'b0;
         wr_ptr_q    <= '0;
         entries_q   <= '0;
         remain_q    <= '0;
      end else begin
         state_q     <= state_d;
         triggered_q <= triggered_d;
         wr_ptr_q    <= wr_ptr_d;
         entries_q   <= entries_d;
         remain_q    <= remain_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         pc_mem[wr_ptr_q]    <= trace_pc;
         instr_mem[wr_ptr_q] <= trace_instr;
         watch_mem[wr_ptr_q] <= watch_data;
      end
   end

`ifdef PP_TRACE_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;
   logic [TS_W-1:0] ts_mem [DEPTH];

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         ts_mem[wr_ptr_q] <= ts_q;
      end
   end

   assign ts_rd = ts_mem[rd_addr];
`else
   assign ts_rd = '0;
`endif

   // Once full, the oldest entry sits at wr_ptr, so logical index is rotated.
   assign rd_hit  = ({1'b0, rd_idx} < entries_q);
   assign rd_addr = (entries_q == CNT_FULL) ? (wr_ptr_q + rd_idx) : rd_idx;

   always_comb begin
      rd_word = '0;
      if (rd_hit) begin
         if (rd_field == FW'(0)) begin
            rd_word = pc_mem[rd_addr];
         end else if (rd_field == FW'(1)) begin
            rd_word = instr_mem[rd_addr];
         end else if (rd_field == FW'(NUM_CH + 2)) begin
            rd_word = XLEN'(ts_rd);
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (rd_field == FW'(c + 2)) begin
               rd_word = watch_mem[rd_addr][c*XLEN +: XLEN];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_data_q <= rd_word;
         end
      end
   end

   assign state     = state_q;
   assign triggered = triggered_q;
   assign wr_ptr    = wr_ptr_q;
   assign entries   = entries_q;
   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;

endmodule
